// File: rtl/mul_cpa.sv
// mul_cpa: multi-cycle carry-propagate adder for the multiplier back end.
// Adds the carry-save sum/carry pair from the CSA tree one CHUNK_WIDTH
// slice per cycle, ripples a registered carry between chunks, and returns
// the selected product word with its tag to multiplier writeback.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid && ready are both high. in_ready is high only in IDLE, and out_valid
// is high only in DONE. Both are decoded straight from the state register, so
// neither depends combinationally on in_valid or out_ready. While out_valid is
// high and out_ready is low, out_result and out_tag hold steady. A flush
// overrides both handshakes in the same cycle. A simultaneous input transfer
// is dropped. A simultaneous output transfer is treated as consumed.
module mul_cpa #(
   parameter int WORD_WIDTH            = 32,
   parameter int PARTIAL_PRODUCT_WIDTH = 2 * (WORD_WIDTH + 1),
   parameter int CHUNK_WIDTH           = 22,
   parameter int TAG_WIDTH             = 6
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [PARTIAL_PRODUCT_WIDTH-1:0] in_sum,
   input  logic [PARTIAL_PRODUCT_WIDTH-1:0] in_carry,
   input  logic                             in_hi,
   input  logic [TAG_WIDTH-1:0]             in_tag,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WORD_WIDTH-1:0]            out_result,
   output logic [TAG_WIDTH-1:0]             out_tag,
   output logic [1:0]                       dbg_state
);

   localparam int NUM_CHUNKS = PARTIAL_PRODUCT_WIDTH / CHUNK_WIDTH;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   // Encoding of the state register
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                       state_q, state_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic                             chunk_carry_q, chunk_carry_d;
   logic [PARTIAL_PRODUCT_WIDTH-1:0] sum_q, sum_d;
   logic [PARTIAL_PRODUCT_WIDTH-1:0] carry_q, carry_d;
   logic [PARTIAL_PRODUCT_WIDTH-1:0] result_q, result_d;
   logic                             hi_q, hi_d;
   logic [TAG_WIDTH-1:0]             tag_q, tag_d;

   // One CHUNK_WIDTH adder, shared by every chunk; bit CHUNK_WIDTH is carry-out
   logic [CHUNK_WIDTH:0]             chunk_add;

   // Select the current chunk of sum/carry and add it with the inter-chunk carry
   always_comb begin
      chunk_add = '0;
      for (int c = 0; c < NUM_CHUNKS; c++) begin
         if (idx_q == IDX_W'(c)) begin
            chunk_add = {1'b0, sum_q[c*CHUNK_WIDTH +: CHUNK_WIDTH]}
                      + {1'b0, carry_q[c*CHUNK_WIDTH +: CHUNK_WIDTH]}
                      + (CHUNK_WIDTH + 1)'(chunk_carry_q);
         end
      end
   end

   // Next-state logic: capture in IDLE, resolve one chunk per cycle in ADD,
   // hold the result in DONE until it is taken; flush wins over everything
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      chunk_carry_d = chunk_carry_q;
      sum_d         = sum_q;
      carry_d       = carry_q;
      result_d      = result_q;
      hi_d          = hi_q;
      tag_d         = tag_q;

      if (flush) begin
         state_d       = ST_IDLE;
         idx_d         = '0;
         chunk_carry_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  sum_d         = in_sum;
                  carry_d       = in_carry;
                  hi_d          = in_hi;
                  tag_d         = in_tag;
                  idx_d         = '0;
                  chunk_carry_d = 1'b0;
                  state_d       = ST_ADD;
               end
            end

            ST_ADD: begin
               for (int c = 0; c < NUM_CHUNKS; c++) begin
                  if (idx_q == IDX_W'(c)) begin
                     result_d[c*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_add[CHUNK_WIDTH-1:0];
                  end
               end
               if (idx_q == LAST_IDX) begin
                  // Carry out of the top chunk is dropped: arithmetic is
                  // modulo 2^PARTIAL_PRODUCT_WIDTH
                  idx_d         = '0;
                  chunk_carry_d = 1'b0;
                  state_d       = ST_DONE;
               end else begin
                  idx_d         = idx_q + 1'b1;
                  chunk_carry_d = chunk_add[CHUNK_WIDTH];
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
               end
            end

            default: begin
               state_d       = ST_IDLE;
               idx_d         = '0;
               chunk_carry_d = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         chunk_carry_q <= 1'b0;
         sum_q         <= '0;
         carry_q       <= '0;
         result_q      <= '0;
         hi_q          <= 1'b0;
         tag_q         <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         chunk_carry_q <= chunk_carry_d;
         sum_q         <= sum_d;
         carry_q       <= carry_d;
         result_q      <= result_d;
         hi_q          <= hi_d;
         tag_q         <= tag_d;
      end
   end

   // Handshake flags are pure decodes of the state register
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);

   // Word select from registered result; a constant shift, no arithmetic
   assign out_result = WORD_WIDTH'(hi_q ? (result_q >> WORD_WIDTH) : result_q);
   assign out_tag    = tag_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mul_cpa.sv
// tb_mul_cpa: directed-vector bench for mul_cpa. A table of sum/carry pairs
// with hand-computed words runs through a loop. Hand-written sequences then
// cover backpressure, flush in each state and asynchronous reset.
module tb_mul_cpa;

   localparam int W   = 32;
   localparam int PPW = 66;
   localparam int TW  = 6;

   logic           clk;
   logic           rst_n;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [PPW-1:0] in_sum;
   logic [PPW-1:0] in_carry;
   logic           in_hi;
   logic [TW-1:0]  in_tag;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_result;
   logic [TW-1:0]  out_tag;
   logic [1:0]     dbg_state;

   int checks;
   int errors;

   typedef struct {
      logic [PPW-1:0] sum;
      logic [PPW-1:0] carry;
      logic           hi;
      logic [TW-1:0]  tag;
      logic [W-1:0]   exp;
   } vec_t;

   vec_t vecs[10];

   mul_cpa dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_carry   (in_carry),
      .in_hi      (in_hi),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .dbg_state  (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [PPW-1:0] act, input logic [PPW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge after the accept edge
   task automatic start_op(input logic [PPW-1:0] s, input logic [PPW-1:0] c,
                           input logic h, input logic [TW-1:0] t);
      check("accept_ready", in_ready, 1);
      in_sum   = s;
      in_carry = c;
      in_hi    = h;
      in_tag   = t;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts cycles from the accept edge until out_valid, bounded
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      out_ready = 1'b1;
      start_op(v.sum, v.carry, v.hi, v.tag);
      wait_valid(lat);
      check("latency", lat, 3);
      check("result", out_result, v.exp);
      check("tag", out_tag, v.tag);
      @(negedge clk);
      check("idle_valid", out_valid, 0);
      check("idle_ready", in_ready, 1);
   endtask

   initial begin
      logic [PPW-1:0] ones;
      int lat;
      logic seen;

      checks    = 0;
      errors    = 0;
      ones      = {PPW{1'b1}};
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = '0;
      in_hi     = 1'b0;
      in_tag    = '0;
      out_ready = 1'b0;

      vecs[0] = '{sum: 66'h3,                   carry: 66'h5,                   hi: 1'b0, tag: 6'h11, exp: 32'h0000_0008};
      vecs[1] = '{sum: 66'h3F_FFFF,             carry: 66'h1,                   hi: 1'b0, tag: 6'h01, exp: 32'h0040_0000};
      vecs[2] = '{sum: 66'hFFF_FFFF_FFFF,       carry: 66'h1,                   hi: 1'b1, tag: 6'h02, exp: 32'h0000_1000};
      vecs[3] = '{sum: ones,                    carry: 66'h0,                   hi: 1'b1, tag: 6'h03, exp: 32'hFFFF_FFFF};
      vecs[4] = '{sum: ones,                    carry: 66'h1,                   hi: 1'b0, tag: 6'h04, exp: 32'h0000_0000};
      vecs[5] = '{sum: ones,                    carry: 66'h1,                   hi: 1'b1, tag: 6'h05, exp: 32'h0000_0000};
      vecs[6] = '{sum: 66'h1234_5678,           carry: 66'h1111_1111,           hi: 1'b0, tag: 6'h06, exp: 32'h2345_6789};
      vecs[7] = '{sum: 66'hFFFF_FFFF,           carry: 66'h1,                   hi: 1'b1, tag: 6'h0A, exp: 32'h0000_0001};
      vecs[8] = '{sum: 66'h3_DEAD_BEEF_0000_0000, carry: 66'h0_1111_1111_0000_0000, hi: 1'b1, tag: 6'h2F, exp: 32'hEFBE_D000};
      vecs[9] = '{sum: 66'h0_FFFF_FFFF_FFFF_FFFF, carry: 66'h1,                 hi: 1'b1, tag: 6'h3E, exp: 32'h0000_0000};

      // Reset values
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_tag", out_tag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i]);
      end

      // Backpressure: hold the result for 5 cycles, in_valid pulses ignored
      out_ready = 1'b0;
      start_op(66'h5_0000_0000, 66'h3_0000_0000, 1'b1, 6'h07);
      wait_valid(lat);
      check("bp_latency", lat, 3);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_result", out_result, 32'h0000_0008);
         check("bp_tag", out_tag, 6'h07);
         check("bp_in_ready", in_ready, 0);
         in_valid = (i % 2 == 0);
         in_tag   = 6'h3F;
         in_sum   = 66'h1234;
         in_hi    = 1'b0;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      check("bp_hold_last", out_result, 32'h0000_0008);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      run_vec('{sum: 66'h100, carry: 66'h23, hi: 1'b0, tag: 6'h08, exp: 32'h0000_0123});

      // Flush in the second ADD cycle
      start_op(66'h7, 66'h9, 1'b0, 6'h2A);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_add_ready", in_ready, 1);
      check("flush_add_valid", out_valid, 0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen = seen | out_valid;
         @(negedge clk);
      end
      check("flush_add_no_result", seen, 0);

      // Flush together with in_valid in IDLE: nothing accepted
      in_sum   = 66'h55;
      in_carry = 66'h0;
      in_tag   = 6'h15;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush_idle_ready", in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen = seen | out_valid;
         @(negedge clk);
      end
      check("flush_idle_no_result", seen, 0);

      // Flush in DONE with the consumer stalled
      out_ready = 1'b0;
      start_op(66'h10, 66'h20, 1'b0, 6'h33);
      wait_valid(lat);
      check("flush_done_latency", lat, 3);
      check("flush_done_result", out_result, 32'h0000_0030);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_done_valid", out_valid, 0);
      check("flush_done_ready", in_ready, 1);

      // Asynchronous reset between clock edges during ADD
      out_ready = 1'b1;
      start_op(66'h1_2345_6789, 66'h1, 1'b0, 6'h3C);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check("arst_out_result", out_result, 0);
      check("arst_out_tag", out_tag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec('{sum: 66'h1, carry: 66'h1, hi: 1'b0, tag: 6'h01, exp: 32'h0000_0002});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
